// File: rtl/reader_sequencer.sv
// reader_sequencer
//
// Controller for a char-stream reader. On an accepted start it enables the
// reader with the latched document selector. It throttles the reader with
// rd_pause so that no character is lost, and buffers characters in a small
// FIFO. The FIFO head is presented downstream as a valid/ready stream. When
// the reader reports it has finished and the FIFO has drained, it pulses done
// and drops rd_enable, which resets the reader.
//
// Ports:
//   clock, resetn            clock (rising edge), asynchronous active-low reset
//   start, doc_sel           begin a read (IDLE only), document selector
//   abort                    cancel the current read, highest priority
//   busy, done               not-IDLE flag, one-cycle end-of-read pulse
//   rd_enable, rd_argument   reader state_enable / argument
//   rd_pause                 reader pause (combinational)
//   rd_finished, rd_char     reader has_finished / char
//   out_char, out_valid      FIFO head and not-empty flag
//   out_ready                downstream accepts the head
//   char_count               chars popped in the current/last read (saturating)
//
// Optional feature macro: READER_DROP_NUL_EN
//   When defined, a captured char equal to zero is neither pushed nor counted.
//   Issue and pause accounting is the same with or without it.

module reader_sequencer #(
    parameter int DEPTH  = 4,
    parameter int CHAR_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [7:0]        doc_sel,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rd_enable,
    output logic [7:0]        rd_argument,
    output logic              rd_pause,
    input  logic              rd_finished,
    input  logic [CHAR_W-1:0] rd_char,
    output logic [CHAR_W-1:0] out_char,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       char_count
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              inflight_q, inflight_d;
    logic [7:0]        arg_q, arg_d;
    logic [15:0]       count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       fifo_count_q, fifo_count_d;
    logic [CHAR_W-1:0] mem_q [DEPTH];

    logic accept_start;
    logic flush;
    logic capture;
    logic push;
    logic pop;

    assign flush        = abort && (state_q != ST_IDLE);
    assign accept_start = (state_q == ST_IDLE) && start && !abort;

    // Pause counts the char already requested but not yet captured, so a
    // full FIFO can never be overrun by the one-cycle reader latency.
    assign rd_pause = (state_q != ST_RUN) ||
                      ((fifo_count_q + {{AW{1'b0}}, inflight_q}) >= DEPTH_C);

    // The reader raises has_finished without presenting a new char, so the
    // issue slot that coincides with rd_finished carries no data.
    assign capture = inflight_q && !rd_finished && !flush;

`ifdef READER_DROP_NUL_EN
    assign push = capture && (rd_char != '0);
`else
    assign push = capture;
`endif

    assign out_valid   = (fifo_count_q != '0);
    assign pop         = out_valid && out_ready;
    assign out_char    = mem_q[rd_ptr_q];
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign rd_enable   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign rd_argument = arg_q;
    assign char_count  = count_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept_start) state_d = ST_RUN;
            ST_RUN:   if (rd_finished) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_count_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // A char is requested on every un-paused RUN cycle before the reader finishes.
    always_comb begin
        inflight_d = (state_q == ST_RUN) && !rd_pause && !rd_finished && !flush;
        arg_d      = accept_start ? doc_sel : arg_q;
        count_d    = count_q;
        if (accept_start) begin
            count_d = '0;
        end else if (pop && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fifo_count_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count_d = fifo_count_q + (AW+1)'(1);
                2'b01:   fifo_count_d = fifo_count_q - (AW+1)'(1);
                default: fifo_count_d = fifo_count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            inflight_q   <= 1'b0;
            arg_q        <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
            arg_q        <= arg_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    // Storage is reset so that out_char reads zero out of reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= rd_char;
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
        !(push && (fifo_count_q == DEPTH_C)));

endmodule
